// File: rtl/swp_sequencer.sv
// swp_sequencer -- executes ARM SWP / SWPB as a locked read, a locked write,
// then a writeback of the old memory value to Rd.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   start               begin a swap (sampled only while idle)
//   is_byte, addr,      SWPB select, Rn (swap address), Rm (store data);
//   rm_data             latched on start, free to change afterwards
//   busy                high in every non-idle state
//   done / abort        single-cycle completion / timeout pulses
//   mem_*               data-memory port; mem_lock spans READ and WRITE
//   rd_we, rd_wdata     register-file writeback of the old memory value
//
// Optional feature: define SWP_TIMEOUT_EN to abort a memory phase after
// TIMEOUT_CYCLES wait cycles. Without it abort is tied low and the
// controller waits on mem_ready indefinitely.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start, all outputs low
// ST_READ  | locked read of [Rn], old value captured into tmp_q
// ST_WRITE | locked write of Rm (or replicated byte) to [Rn]
// ST_WB    | rd_we + done for one cycle, then back to idle

module swp_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        is_byte,
   input  logic [31:0] addr,
   input  logic [31:0] rm_data,
   output logic        busy,
   output logic        done,
   output logic        abort,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_lock,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        rd_we,
   output logic [31:0] rd_wdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_WB    = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] addr_q, rm_q, tmp_q;
   logic        byte_q;
   logic        busy_q, done_q, req_q, we_q, lock_q, rd_we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q, rd_wdata_q;

   logic [31:0] rdata_rot_d, rdata_fmt_d, wdata_d;
   logic [3:0]  be_d;

   // Rotating right by the byte offset gives the ARM unaligned-word result,
   // and also brings the addressed byte lane down to bits 7:0.
   always_comb begin
      rdata_rot_d = 32'({mem_rdata, mem_rdata} >> {addr_q[1:0], 3'b000});
      if (byte_q) begin
         rdata_fmt_d = {24'h0, rdata_rot_d[7:0]};
         wdata_d     = {4{rm_q[7:0]}};
         be_d        = 4'b0001 << addr_q[1:0];
      end else begin
         rdata_fmt_d = rdata_rot_d;
         wdata_d     = rm_q;
         be_d        = 4'b1111;
      end
   end

`ifdef SWP_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_q;
   logic              abort_q;
   logic              wait_expired_d;

   // The cycle that would bring the count to TIMEOUT_CYCLES ends the phase.
   assign wait_expired_d = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
   assign abort          = abort_q;
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rm_q       <= '0;
         byte_q     <= 1'b0;
         tmp_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         lock_q     <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         rd_we_q    <= 1'b0;
         rd_wdata_q <= '0;
`ifdef SWP_TIMEOUT_EN
         wait_q     <= '0;
         abort_q    <= 1'b0;
`endif
      end else begin
         done_q  <= 1'b0;
         rd_we_q <= 1'b0;
`ifdef SWP_TIMEOUT_EN
         abort_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q  <= addr;
                  rm_q    <= rm_data;
                  byte_q  <= is_byte;
                  state_q <= ST_READ;
                  busy_q  <= 1'b1;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  lock_q  <= 1'b1;
                  be_q    <= 4'b1111;
`ifdef SWP_TIMEOUT_EN
                  wait_q  <= '0;
`endif
               end
            end
            ST_READ: begin
               if (mem_ready) begin
                  tmp_q   <= rdata_fmt_d;
                  state_q <= ST_WRITE;
                  we_q    <= 1'b1;
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
`ifdef SWP_TIMEOUT_EN
                  wait_q  <= '0;
               end else if (wait_expired_d) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  lock_q  <= 1'b0;
                  be_q    <= '0;
                  abort_q <= 1'b1;
               end else begin
                  wait_q  <= wait_q + 1'b1;
`endif
               end
            end
            ST_WRITE: begin
               if (mem_ready) begin
                  state_q    <= ST_WB;
                  req_q      <= 1'b0;
                  we_q       <= 1'b0;
                  lock_q     <= 1'b0;
                  be_q       <= '0;
                  wdata_q    <= '0;
                  rd_we_q    <= 1'b1;
                  rd_wdata_q <= tmp_q;
                  done_q     <= 1'b1;
`ifdef SWP_TIMEOUT_EN
               end else if (wait_expired_d) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  lock_q  <= 1'b0;
                  be_q    <= '0;
                  wdata_q <= '0;
                  abort_q <= 1'b1;
               end else begin
                  wait_q  <= wait_q + 1'b1;
`endif
               end
            end
            ST_WB: begin
               state_q    <= ST_IDLE;
               busy_q     <= 1'b0;
               rd_wdata_q <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_lock  = lock_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;
   assign rd_we     = rd_we_q;
   assign rd_wdata  = rd_wdata_q;
   // Address is only presented while a request is active so idle stays all-zero.
   assign mem_addr  = req_q ? {addr_q[31:2], 2'b00} : 32'h0;

endmodule
